// File: rtl/bitrev_reorder_pkg.sv
// Shared definitions for the bit-reverse reorder buffer.
//   MaxStage   : widest index the bit-reverse helper supports
//   rd_state_e : read-side FSM states
//   clamp_l    : clamps a requested log2 frame length to 1..total
//   bitrev     : reverses the low l bits of an index, upper bits zero
package bitrev_reorder_pkg;

  localparam int unsigned MaxStage = 16;

  typedef enum logic [0:0] {
    StIdle,
    StRead
  } rd_state_e;

  function automatic int unsigned clamp_l(input int unsigned raw, input int unsigned total);
    if (raw < 1) begin
      return 1;
    end else if (raw > total) begin
      return total;
    end else begin
      return raw;
    end
  endfunction

  // Reverse all MaxStage bits, then shift down so only the low l bits survive.
  // Callers pass indices below 2^l, so nothing above bit l-1 leaks in.
  function automatic logic [MaxStage-1:0] bitrev(input logic [MaxStage-1:0] x,
                                                 input int unsigned l);
    logic [MaxStage-1:0] full;
    for (int i = 0; i < int'(MaxStage); i++) begin
      full[i] = x[MaxStage-1-i];
    end
    return full >> (MaxStage - l);
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port storage for the ping-pong reorder buffer.
//   clk   : write and read clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable, raddr : read address
//   rdata : registered read data, valid the cycle after re
// The address MSB selects the bank; contents are never reset.
module reorder_ram #(
  parameter int unsigned AddrWidth = 11,
  parameter int unsigned DataWidth = 36
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bitrev_reorder.sv
// Bit-reverse reorder buffer: writes frames in natural order into one bank
// of a ping-pong RAM while the other bank is read back in bit-reversed (or
// natural, in bypass) order.
//   clk, rst_n : clock, asynchronous active-low reset
//   ilog2n     : log2 frame length, sampled on the first ien of a frame
//   ibypass    : 1 = natural output order, sampled with ilog2n
//   ien, idata : input sample strobe and {re,im} data
//   oen, osof  : output valid and start-of-frame
//   oaddr      : output index 0..N-1, zero while idle
//   odata      : output sample
// Last input at cycle t gives the first output at t+2.
module bitrev_reorder #(
  parameter int unsigned TOTAL_STAGE_P = 10,
  parameter int unsigned MULT_WIDTH_P  = 18
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [$clog2(TOTAL_STAGE_P+1)-1:0] ilog2n,
  input  logic                               ibypass,
  input  logic                               ien,
  input  logic [2*MULT_WIDTH_P-1:0]          idata,
  output logic                               oen,
  output logic                               osof,
  output logic [TOTAL_STAGE_P-1:0]           oaddr,
  output logic [2*MULT_WIDTH_P-1:0]          odata
);

  import bitrev_reorder_pkg::*;

  localparam int unsigned Stages = TOTAL_STAGE_P;
  localparam int unsigned LWidth = $clog2(TOTAL_STAGE_P + 1);
  localparam int unsigned DWidth = 2 * MULT_WIDTH_P;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [Stages-1:0] wcnt_q;
  logic              wbank_q;
  logic [LWidth-1:0] wl_q;
  logic              wbyp_q;

  logic [LWidth-1:0] cur_l;
  logic              cur_byp;
  logic [Stages-1:0] wmax;
  logic              start;

  // wcnt == 0 means no frame in progress, so the live inputs set the length.
  always_comb begin
    cur_l   = wl_q;
    cur_byp = wbyp_q;
    if (wcnt_q == '0) begin
      cur_l   = LWidth'(clamp_l(32'(ilog2n), Stages));
      cur_byp = ibypass;
    end
    wmax  = Stages'((32'd1 << cur_l) - 32'd1);
    start = ien && (wcnt_q == wmax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      wl_q    <= LWidth'(1);
      wbyp_q  <= 1'b0;
    end else if (ien) begin
      wl_q   <= cur_l;
      wbyp_q <= cur_byp;
      if (start) begin
        wcnt_q  <= '0;
        wbank_q <= ~wbank_q;
      end else begin
        wcnt_q <= wcnt_q + Stages'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side FSM
  // ---------------------------------------------------------------------------
  rd_state_e         state_q;
  logic [Stages-1:0] rcnt_q;
  logic              rbank_q;
  logic [LWidth-1:0] rl_q;
  logic              rbyp_q;

  // A start that lands mid-read (frame shorter than the one being drained)
  // waits here until the current read finishes.
  logic              pend_q;
  logic              pbank_q;
  logic [LWidth-1:0] pl_q;
  logic              pbyp_q;

  logic [Stages-1:0] rmax;
  logic [Stages-1:0] rd_idx;
  logic              ren;

  always_comb begin
    rmax   = Stages'((32'd1 << rl_q) - 32'd1);
    ren    = (state_q == StRead);
    rd_idx = rcnt_q;
    if (!rbyp_q) begin
      rd_idx = Stages'(bitrev(MaxStage'(rcnt_q), 32'(rl_q)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
      rl_q    <= LWidth'(1);
      rbyp_q  <= 1'b0;
      pend_q  <= 1'b0;
      pbank_q <= 1'b0;
      pl_q    <= LWidth'(1);
      pbyp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRead;
            rcnt_q  <= '0;
            rbank_q <= wbank_q;
            rl_q    <= cur_l;
            rbyp_q  <= cur_byp;
          end
        end
        StRead: begin
          if (start) begin
            pbank_q <= wbank_q;
            pl_q    <= cur_l;
            pbyp_q  <= cur_byp;
          end
          if (rcnt_q == rmax) begin
            rcnt_q <= '0;
            if (pend_q) begin
              rbank_q <= pbank_q;
              rl_q    <= pl_q;
              rbyp_q  <= pbyp_q;
              pend_q  <= start;
            end else if (start) begin
              // Back-to-back frame: continue on the other bank with no gap.
              rbank_q <= wbank_q;
              rl_q    <= cur_l;
              rbyp_q  <= cur_byp;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            rcnt_q <= rcnt_q + Stages'(1);
            if (start) begin
              pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DWidth-1:0] rdata;

  reorder_ram #(
    .AddrWidth(Stages + 1),
    .DataWidth(DWidth)
  ) u_ram (
    .clk  (clk),
    .we   (ien),
    .waddr({wbank_q, wcnt_q}),
    .wdata(idata),
    .re   (ren),
    .raddr({rbank_q, rd_idx}),
    .rdata(rdata)
  );

  // ---------------------------------------------------------------------------
  // Output pipeline: s1 tracks the RAM read stage, then the output registers.
  // ---------------------------------------------------------------------------
  logic              s1_valid_q;
  logic              s1_sof_q;
  logic [Stages-1:0] s1_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_addr_q  <= '0;
      oen        <= 1'b0;
      osof       <= 1'b0;
      oaddr      <= '0;
      odata      <= '0;
    end else begin
      s1_valid_q <= ren;
      s1_sof_q   <= ren && (rcnt_q == '0);
      s1_addr_q  <= rcnt_q;
      oen        <= s1_valid_q;
      osof       <= s1_valid_q && s1_sof_q;
      oaddr      <= s1_valid_q ? s1_addr_q : '0;
      if (s1_valid_q) begin
        odata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
module tb_bitrev_reorder;

  localparam int TS = 10;
  localparam int MW = 18;
  localparam int DW = 2 * MW;
  localparam int LW = $clog2(TS + 1);

  logic          clk;
  logic          rst_n;
  logic [LW-1:0] ilog2n;
  logic          ibypass;
  logic          ien;
  logic [DW-1:0] idata;
  logic          oen;
  logic          osof;
  logic [TS-1:0] oaddr;
  logic [DW-1:0] odata;

  bitrev_reorder #(
    .TOTAL_STAGE_P(TS),
    .MULT_WIDTH_P (MW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ilog2n (ilog2n),
    .ibypass(ibypass),
    .ien    (ien),
    .idata  (idata),
    .oen    (oen),
    .osof   (osof),
    .oaddr  (oaddr),
    .odata  (odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int clampl(input int v);
    if (v < 1) return 1;
    if (v > TS) return TS;
    return v;
  endfunction

  // Reverse the low l bits of k by peeling bits off the bottom.
  function automatic int rev(input int k, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    bit            sof;
    int            n;
  } exp_t;

  exp_t          exp_q[$];
  int            due_q[$];
  logic [DW-1:0] fbuf[$];
  int            fl = 1;
  bit            fbyp = 1'b0;
  int            cyc = 0;
  int            last_done_cyc = 0;

  task automatic model_in(input logic [DW-1:0] d);
    exp_t e;
    if (fbuf.size() == 0) begin
      fl   = clampl(int'(ilog2n));
      fbyp = ibypass;
    end
    fbuf.push_back(d);
    if (fbuf.size() == (1 << fl)) begin
      for (int k = 0; k < (1 << fl); k++) begin
        e.addr = k;
        e.data = fbyp ? fbuf[k] : fbuf[rev(k, fl)];
        e.sof  = (k == 0);
        e.n    = 1 << fl;
        exp_q.push_back(e);
      end
      due_q.push_back(cyc + 2);
      last_done_cyc = cyc;
      fbuf.delete();
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      fbuf.delete();
      exp_q.delete();
      due_q.delete();
    end else if (ien) begin
      model_in(idata);
    end
  end

  // ---------------- compare process ----------------
  logic [DW-1:0] cap[8];
  int            capn = 0;
  int            first_oen_cyc = 0;
  int            rem = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_oen", 64'(oen), 64'(0));
      check("rst_osof", 64'(osof), 64'(0));
      check("rst_oaddr", 64'(oaddr), 64'(0));
      check("rst_odata", 64'(odata), 64'(0));
      rem = 0;
    end else if (oen) begin
      if (capn < 8) begin
        if (capn == 0) first_oen_cyc = cyc;
        cap[capn] = odata;
        capn++;
      end
      check("oen_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("oaddr", 64'(oaddr), 64'(e.addr));
        check("odata", 64'(odata), 64'(e.data));
        check("osof", 64'(osof), 64'(e.sof));
        if (e.sof) begin
          check("sof_due_known", 64'(due_q.size() > 0), 64'(1));
          if (due_q.size() > 0) check("first_out_cycle", 64'(cyc), 64'(due_q.pop_front()));
          rem = e.n - 1;
        end else begin
          rem--;
        end
      end
    end else begin
      check("oaddr_idle", 64'(oaddr), 64'(0));
      check("no_bubble_remaining", 64'(rem), 64'(0));
      rem = 0;
      if (due_q.size() > 0) begin
        check("first_out_not_late", 64'(cyc < due_q[0]), 64'(1));
        if (cyc >= due_q[0]) void'(due_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    ien = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int l_in, input bit byp, input int n, input int gap_pct,
                            input bit toggle, input bit seq);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        ien = 1'b0;
        if (toggle) begin
          ilog2n  = LW'($urandom);
          ibypass = 1'($urandom);
        end
        @(negedge clk);
      end
      ien = 1'b1;
      idata = seq ? DW'(i) : DW'({$urandom(), $urandom()});
      if (i == 0) begin
        ilog2n  = LW'(l_in);
        ibypass = byp;
      end else if (toggle) begin
        ilog2n  = LW'($urandom);
        ibypass = 1'($urandom);
      end
      @(negedge clk);
    end
    ien = 1'b0;
  endtask

  logic [DW-1:0] lit[8];

  initial begin
    rst_n   = 1'b0;
    ien     = 1'b0;
    idata   = '0;
    ilog2n  = LW'(3);
    ibypass = 1'b0;

    // Pin the model's helpers to hand-computed values.
    check("model_rev_1_3", 64'(rev(1, 3)), 64'(4));
    check("model_rev_6_3", 64'(rev(6, 3)), 64'(3));
    check("model_rev_1_10", 64'(rev(1, 10)), 64'(512));
    check("model_clamp_0", 64'(clampl(0)), 64'(1));
    check("model_clamp_15", 64'(clampl(15)), 64'(10));

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // N=8 reverse, inputs 0..7 back-to-back.
    send_frame(3, 1'b0, 8, 0, 1'b0, 1'b1);
    idle(20);
    lit[0] = 0; lit[1] = 4; lit[2] = 2; lit[3] = 6;
    lit[4] = 1; lit[5] = 5; lit[6] = 3; lit[7] = 7;
    check("lit_count", 64'(capn), 64'(8));
    for (int k = 0; k < 8; k++) check($sformatf("lit_odata%0d", k), 64'(cap[k]), 64'(lit[k]));
    check("lit_latency", 64'(first_oen_cyc - last_done_cyc), 64'(2));

    // N=8 bypass.
    send_frame(3, 1'b1, 8, 0, 1'b0, 1'b1);
    idle(20);

    // Three back-to-back N=1024 frames, ien always high.
    for (int f = 0; f < 3; f++) send_frame(10, 1'b0, 1024, 0, 1'b0, 1'b0);
    idle(1100);

    // N=16 then N=4 with random gaps and mid-frame parameter toggling.
    send_frame(4, 1'b0, 16, 30, 1'b1, 1'b0);
    idle(40);
    send_frame(2, 1'b0, 4, 40, 1'b1, 1'b0);
    idle(20);
    send_frame(2, 1'b1, 4, 40, 1'b1, 1'b0);
    idle(20);

    // Reset after 5 of 8 inputs; partial frame is discarded.
    send_frame(3, 1'b0, 5, 0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(10);
    send_frame(3, 1'b0, 8, 0, 1'b0, 1'b0);
    idle(20);

    // Clamping: ilog2n=0 -> N=2 (back-to-back), ilog2n=15 -> N=1024.
    send_frame(0, 1'b0, 2, 0, 1'b0, 1'b0);
    send_frame(0, 1'b0, 2, 0, 1'b0, 1'b0);
    send_frame(0, 1'b1, 2, 0, 1'b0, 1'b0);
    idle(20);
    send_frame(15, 1'b0, 1024, 0, 1'b0, 1'b0);
    idle(1100);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("partial_frame_empty", 64'(fbuf.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitrev_reorder.md
BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 Parameter TOTAL_STAGE_P, default 10: log2 of the maximum frame length (max N = 2^TOTAL_STAGE_P).
REQ-002 Parameter MULT_WIDTH_P, default 18: width of each real/imag component; one sample is 2*MULT_WIDTH_P bits.
REQ-003 Port clk, input, 1: single clock for the whole block; all logic is rising-edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port ilog2n, input, clog2(TOTAL_STAGE_P+1): runtime log2 of frame length; sampled on the first ien of each frame.
REQ-006 Port ibypass, input, 1: 1 = output in natural order, 0 = bit-reversed; sampled with ilog2n.
REQ-007 Port ien, input, 1: input sample valid.
REQ-008 Port idata, input, 2*MULT_WIDTH_P: input sample {re,im}, natural order.
REQ-009 Port oen, output, 1: output sample valid.
REQ-010 Port osof, output, 1: first sample of an output frame; qualified by oen.
REQ-011 Port oaddr, output, TOTAL_STAGE_P: output sample index 0..N-1, natural count.
REQ-012 Port odata, output, 2*MULT_WIDTH_P: output sample.

Function
REQ-013 Ping-pong buffer: two banks of 2^TOTAL_STAGE_P words; write side fills one bank while read side drains the other.
REQ-014 Write counter wcnt increments on each ien; sample stored at bank[wbank][wcnt]; ien without a frame in progress starts a new frame.
REQ-015 Frame length N = 2^L, L = ilog2n clamped to range 1..TOTAL_STAGE_P; L and ibypass latched per frame and carried to the read side with the bank.
REQ-016 On the ien with wcnt == N-1: wcnt clears to 0, wbank toggles, read-start request issued with latched L and mode.
REQ-017 Read side states: IDLE, READ; IDLE->READ on read-start; READ->IDLE after issuing N reads unless a new read-start arrives in the same cycle, which goes straight to READ on the other bank with no gap.
REQ-018 Read address in bank = bitrev_L(rcnt) in reverse mode, rcnt in bypass mode; bitrev_L reverses bits [L-1:0], upper bits zero.
REQ-019 Latency: last ien of frame at cycle t -> first oen (osof=1, oaddr=0) at t+2; subsequent outputs on consecutive cycles; oaddr increments 0..N-1.
REQ-020 Output N: odata at oaddr=k equals input sample number bitrev_L(k), or number k in bypass mode.
REQ-021 Continuous input (ien every cycle) yields continuous output with no bubbles and no overflow; no backpressure exists.
REQ-022 ien gaps within a frame are allowed; wcnt holds during gaps.
REQ-023 Changes of ilog2n/ibypass mid-frame are ignored until the next frame starts.
REQ-024 oen, osof, oaddr, odata registered; odata is don't-care when oen=0, oaddr holds 0 when oen=0.

Reset
REQ-025 rst_n low asynchronously clears wcnt, rcnt, wbank, rbank, read state to IDLE, oen=0, osof=0, oaddr=0, odata=0.
REQ-026 Reset mid-frame discards the partial input frame and any frame being read; memory contents are not cleared.
REQ-027 First ien after rst_n deassertion starts a new frame at wcnt=0.

Structure
REQ-028 A shared package holds the bit-reverse function, the clamped-L helper and the read-state enum.
REQ-029 The storage is one sub-module, reorder_ram: simple dual-port, one write port, one registered read port, 2*2^TOTAL_STAGE_P words; bank select is the address MSB.
REQ-030 The top level contains only counters, bank toggles, read FSM and output registers.

Verification
REQ-031 N=8 (ilog2n=3), reverse, inputs 0..7 back-to-back -> oaddr 0..7 with odata 0,4,2,6,1,5,3,7; first oen 2 cycles after last ien.
REQ-032 N=8, ibypass=1 -> odata 0..7 in order with the same latency.
REQ-033 Three back-to-back N=1024 frames, ien always high -> 3072 consecutive oen cycles, osof at 0/1024/2048, each frame bit-reversed correctly.
REQ-034 Frame N=16 followed by frame N=4 (ilog2n changed between frames), random ien gaps -> each frame reordered at its own length; ilog2n toggled mid-frame has no effect.
REQ-035 rst_n pulsed after 5 of 8 inputs -> oen stays 0; next 8 inputs produce one correct frame.
REQ-036 ilog2n=0 and ilog2n=15 with TOTAL_STAGE_P=10 -> treated as N=2 and N=1024 respectively.
